hazard_ctrl: RTL and testbench
==============================

Name: hazard_ctrl

Overview:
Central pipeline sequencer for the 5-stage datapath.
- Detects load-use hazards between ID and EX.
- Sequences the multi-cycle multiply/divide unit and stalls dependent instructions.
- Flushes the younger stages when MEM resolves a taken branch, J or JR.
- Drives the hold, bubble and flush controls of PC, IFID, IDEX and ExMem. Replaces the ad-hoc loadad and jumpSuccess gating.

Parameters:
MD_LAT, 8, mult/div latency in cycles (legal range 2..255)
CNT_W, 16, width of the stall-cycle counter

Ports:
clk  in  1  pipeline clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
id_valid  in  1  ID stage holds a real instruction
id_rs  in  5  ID source register rs
id_rt  in  5  ID source register rt
id_uses_rt  in  1  ID instruction reads rt as an operand
id_md_start  in  1  ID instruction is MULT/DIV
id_md_read  in  1  ID instruction is MFHI/MFLO
ex_rw  in  5  EX destination register
ex_regwr  in  1  EX instruction writes a register
ex_memtoreg  in  1  EX instruction is a load
mem_redirect  in  1  MEM taken branch / J / JR (jumpSuccess)
pc_hold  out  1  PC keeps its value
ifid_hold  out  1  IFID keeps its contents
idex_bubble  out  1  IDEX loads a NOP (all write/branch controls 0)
ifid_flush  out  1  IFID loads a NOP
idex_flush  out  1  IDEX loads a NOP
exmem_flush  out  1  ExMem loads a NOP
md_busy  out  1  mult/div unit is computing
md_done  out  1  one-cycle pulse when the result is ready
stall_cnt  out  CNT_W  cycles with pc_hold=1 (see Optional Feature)

Behaviour:
- Reset values (while reset=0): state=RUN, md counter=0, md_busy=0, md_done=0, stall_cnt=0.
- Reset values of combinational outputs: pc_hold, ifid_hold, idex_bubble and all flush outputs are 0 while reset=0.
- Hazard terms are combinational from inputs and state:
  - lu = id_valid & ex_memtoreg & ex_regwr & ex_rw!=0 & (ex_rw==id_rs | (id_uses_rt & ex_rw==id_rt))
  - md_hz = id_valid & md_busy & (id_md_start | id_md_read)
- Output priority, highest first:
  1. mem_redirect=1: ifid_flush=idex_flush=exmem_flush=1, and pc_hold=ifid_hold=idex_bubble=0 in the same cycle.
  2. md_hz: pc_hold=ifid_hold=idex_bubble=1.
  3. lu: pc_hold=ifid_hold=idex_bubble=1 for exactly one cycle. The load then moves to MEM and lu deasserts.
  4. Otherwise all hold, bubble and flush outputs are 0.
- State machine, states RUN, MD_WAIT, REDIRECT:
  - RUN -> REDIRECT on mem_redirect.
  - RUN -> MD_WAIT on md_hz without mem_redirect.
  - MD_WAIT -> RUN when md_hz drops. MD_WAIT -> REDIRECT on mem_redirect.
  - REDIRECT -> RUN after one cycle.
  - In REDIRECT, a second mem_redirect is ignored, because the ExMem slot holds the flushed NOP. Outputs then follow priorities 2-4.
- Mult/div sequencing:
  - Start accepted when id_valid & id_md_start & !md_busy & !mem_redirect & !lu.
  - On start, the counter loads MD_LAT-1 and md_busy=1 from the next cycle.
  - The counter decrements every cycle while busy, and keeps running during stalls and redirects.
  - When the counter reads 0 while busy: md_done=1 for that cycle and md_busy=0 next cycle. md_hz therefore releases the cycle after md_done.
  - A start that coincides with mem_redirect is dropped, because the ID instruction is flushed.
  - A new start is accepted in the cycle md_busy reads 0, which allows back-to-back operations.
- Reset asserted mid-operation clears the counter and busy state. No md_done is emitted.

Optional Feature:
STALL_CNT_EN
- Defined: stall_cnt increments on every rising edge where pc_hold=1, and saturates at all-ones. It clears only on reset.
- Undefined: the counter logic is removed and stall_cnt is tied to 0. The port remains.

Test Plan:
1. Load-use: ex_memtoreg=1, ex_regwr=1, ex_rw=5, id_rs=5, id_valid=1 -> pc_hold=ifid_hold=idex_bubble=1 for 1 cycle only.
2. Load to $0: ex_rw=0, id_rs=0 -> no stall. Load to 7 with id_rt=7 and id_uses_rt=0 -> no stall.
3. Redirect overrides stall: lu condition and mem_redirect=1 together -> all three flush outputs=1, pc_hold=0. A mem_redirect the next cycle -> ignored (no flush).
4. MD with MD_LAT=8:
   - Stimulus: start at cycle 0, MFHI in ID from cycle 1.
   - Response: md_busy over cycles 1-8, md_done at cycle 8, pc_hold cycles 1-8, MFHI proceeds at cycle 9.
5. Reset mid-MD: reset=0 at cycle 3 of 8 -> md_busy=0 and pc_hold=0 immediately (asynchronous). No md_done after release.
6. STALL_CNT_EN defined, CNT_W=4: 20 stall cycles -> stall_cnt=15 (saturated). Macro undefined -> stall_cnt=0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: load-use, mult/div and redirect sequencer for the 5-stage pipeline.
// Build option: define STALL_CNT_EN to enable the saturating pc_hold cycle counter.
module hazard_ctrl #(
  parameter int MD_LAT = 8,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             id_valid,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             id_md_start,
  input  logic             id_md_read,
  input  logic [4:0]       ex_rw,
  input  logic             ex_regwr,
  input  logic             ex_memtoreg,
  input  logic             mem_redirect,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             md_busy,
  output logic             md_done,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic [1:0] {RUN, MD_WAIT, REDIRECT} state_t;

  localparam logic [7:0] MD_LOAD = 8'(MD_LAT - 1);

  state_t     state;
  logic [7:0] md_cnt;
  logic       lu;
  logic       md_hz;
  logic       redir;
  logic       md_start;
  logic       hold;

  assign lu = id_valid & ex_memtoreg & ex_regwr & (ex_rw != 5'd0) &
              ((ex_rw == id_rs) | (id_uses_rt & (ex_rw == id_rt)));
  assign md_hz = id_valid & md_busy & (id_md_start | id_md_read);

  // A redirect arriving in REDIRECT only sees the flushed NOP in ExMem, so it is ignored.
  assign redir    = mem_redirect & (state != REDIRECT);
  assign md_start = id_valid & id_md_start & ~md_busy & ~redir & ~lu;
  assign md_done  = md_busy & (md_cnt == 8'd0);

  // Redirect outranks both stall sources; everything is forced quiet while reset is low.
  assign hold        = reset & ~redir & (md_hz | lu);
  assign pc_hold     = hold;
  assign ifid_hold   = hold;
  assign idex_bubble = hold;
  assign ifid_flush  = reset & redir;
  assign idex_flush  = reset & redir;
  assign exmem_flush = reset & redir;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= RUN;
      md_cnt  <= 8'd0;
      md_busy <= 1'b0;
    end else begin
      unique case (state)
        RUN: begin
          if (mem_redirect)  state <= REDIRECT;
          else if (md_hz)    state <= MD_WAIT;
        end
        MD_WAIT: begin
          if (mem_redirect)  state <= REDIRECT;
          else if (!md_hz)   state <= RUN;
        end
        REDIRECT: state <= RUN;
        default:  state <= RUN;
      endcase

      // The unit keeps counting through stalls and redirects.
      if (md_busy) begin
        if (md_cnt == 8'd0) md_busy <= 1'b0;
        else                md_cnt  <= md_cnt - 8'd1;
      end else if (md_start) begin
        md_cnt  <= MD_LOAD;
        md_busy <= 1'b1;
      end
    end
  end

`ifdef STALL_CNT_EN
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                               stall_cnt <= '0;
    else if (pc_hold && (stall_cnt != '1))    stall_cnt <= stall_cnt + CNT_ONE;
  end
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios plus random traffic checked
// against a cycle-level behavioural model of the pipeline hazard rules.
module tb_hazard_ctrl;

  localparam int MD_LAT    = 8;
  localparam int CNT_W     = 4;
  localparam int STALL_MAX = (1 << CNT_W) - 1;

  logic             clk;
  logic             reset;
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rt;
  logic             id_md_start;
  logic             id_md_read;
  logic [4:0]       ex_rw;
  logic             ex_regwr;
  logic             ex_memtoreg;
  logic             mem_redirect;
  logic             pc_hold;
  logic             ifid_hold;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             idex_flush;
  logic             exmem_flush;
  logic             md_busy;
  logic             md_done;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(.MD_LAT(MD_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .id_md_start(id_md_start), .id_md_read(id_md_read),
    .ex_rw(ex_rw), .ex_regwr(ex_regwr), .ex_memtoreg(ex_memtoreg),
    .mem_redirect(mem_redirect),
    .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .md_busy(md_busy), .md_done(md_done), .stall_cnt(stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       valid;
    logic [4:0] rs;
    logic [4:0] rt;
    logic [4:0] rw;
    logic       uses_rt;
    logic       md_start;
    logic       md_read;
    logic       regwr;
    logic       memtoreg;
    logic       redirect;
  } stim_t;

  typedef struct {
    int         cyc;
    logic [7:0] ctl;
    int         cnt;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  logic last_redirect = 1'b0;

  // Reference model state: remaining busy cycles, last honoured redirect, stall count.
  int   m_left = 0;
  logic m_redir_prev = 1'b0;
  int   m_stall = 0;

  task automatic check(input string name, input int c, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, c, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rst = 1'b1;
    return s;
  endfunction

  task automatic drive(input stim_t s);
    exp_t e;
    logic busy, done, lu_m, mdhz_m, redir_m, hold_m, start_m;
    @(posedge clk);
    #1;
    reset = s.rst;  id_valid = s.valid;  id_rs = s.rs;  id_rt = s.rt;
    id_uses_rt = s.uses_rt;  id_md_start = s.md_start;  id_md_read = s.md_read;
    ex_rw = s.rw;  ex_regwr = s.regwr;  ex_memtoreg = s.memtoreg;
    mem_redirect = s.redirect;
    last_redirect = s.redirect;
    e.cyc = cyc;
    cyc++;
    if (!s.rst) begin
      m_left = 0;
      m_redir_prev = 1'b0;
      m_stall = 0;
      e.ctl = 8'h00;
      e.cnt = 0;
    end else begin
      busy    = (m_left > 0);
      done    = (m_left == 1);
      lu_m    = s.valid && s.memtoreg && s.regwr && (s.rw != 0) &&
                ((s.rw == s.rs) || (s.uses_rt && (s.rw == s.rt)));
      mdhz_m  = s.valid && busy && (s.md_start || s.md_read);
      redir_m = s.redirect && !m_redir_prev;
      hold_m  = !redir_m && (mdhz_m || lu_m);
      e.ctl   = {hold_m, hold_m, hold_m, redir_m, redir_m, redir_m, busy, done};
`ifdef STALL_CNT_EN
      e.cnt = m_stall;
      if (hold_m && m_stall < STALL_MAX) m_stall++;
`else
      e.cnt = 0;
`endif
      start_m = s.valid && s.md_start && !busy && !redir_m && !lu_m;
      if (busy) m_left--;
      if (start_m) m_left = MD_LAT;
      m_redir_prev = redir_m;
    end
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("ctl{hold,hold,bubble,flush x3,busy,done}", e.cyc,
              32'({pc_hold, ifid_hold, idex_bubble, ifid_flush, idex_flush,
                   exmem_flush, md_busy, md_done}), 32'(e.ctl));
        check("stall_cnt", e.cyc, 32'(stall_cnt), 32'(e.cnt));
      end
    end
  end

  initial begin : stimulus
    stim_t s;
    reset = 1'b0;  id_valid = 1'b0;  id_rs = '0;  id_rt = '0;  id_uses_rt = 1'b0;
    id_md_start = 1'b0;  id_md_read = 1'b0;  ex_rw = '0;  ex_regwr = 1'b0;
    ex_memtoreg = 1'b0;  mem_redirect = 1'b0;

    // Reset held with hazard-looking inputs: every output must stay quiet.
    s = idle();  s.rst = 1'b0;  s.valid = 1'b1;  s.rw = 5;  s.rs = 5;
    s.regwr = 1'b1;  s.memtoreg = 1'b1;  s.md_start = 1'b1;
    repeat (2) drive(s);
    s.redirect = 1'b1;
    drive(s);
    drive(idle());

    // Load-use on rs for one cycle, then the load moves on.
    s = idle();  s.valid = 1'b1;  s.rw = 5;  s.rs = 5;  s.regwr = 1'b1;  s.memtoreg = 1'b1;
    drive(s);
    s.memtoreg = 1'b0;  s.regwr = 1'b0;
    drive(s);

    // Load to $0, and load to rt when rt is not an operand: no stall; then rt used.
    s = idle();  s.valid = 1'b1;  s.rw = 0;  s.rs = 0;  s.regwr = 1'b1;  s.memtoreg = 1'b1;
    drive(s);
    s.rw = 7;  s.rs = 3;  s.rt = 7;  s.uses_rt = 1'b0;
    drive(s);
    s.uses_rt = 1'b1;
    drive(s);

    // Redirect overrides a load-use stall; a back-to-back redirect is ignored.
    s = idle();  s.valid = 1'b1;  s.rw = 9;  s.rs = 9;  s.regwr = 1'b1;  s.memtoreg = 1'b1;
    s.redirect = 1'b1;
    drive(s);
    s = idle();  s.redirect = 1'b1;
    drive(s);
    drive(idle());

    // Multiply then MFHI waiting in ID until the result is ready.
    s = idle();  s.valid = 1'b1;  s.md_start = 1'b1;
    drive(s);
    s = idle();  s.valid = 1'b1;  s.md_read = 1'b1;
    repeat (10) drive(s);
    drive(idle());

    // Reset in the middle of an operation: no md_done afterwards.
    s = idle();  s.valid = 1'b1;  s.md_start = 1'b1;
    drive(s);
    s = idle();  s.valid = 1'b1;  s.md_read = 1'b1;
    repeat (2) drive(s);
    s.rst = 1'b0;
    repeat (2) drive(s);
    repeat (12) drive(idle());

    // 20 consecutive stall cycles to saturate the 4-bit stall counter.
    s = idle();  s.valid = 1'b1;  s.rw = 4;  s.rs = 4;  s.regwr = 1'b1;  s.memtoreg = 1'b1;
    repeat (20) drive(s);
    repeat (2) drive(idle());

    // Random traffic over a small register space so hazards are frequent.
    for (int i = 0; i < 3000; i++) begin
      s.rst      = ($urandom_range(0, 299) != 0);
      s.valid    = ($urandom_range(0, 3) != 0);
      s.rs       = 5'($urandom_range(0, 3));
      s.rt       = 5'($urandom_range(0, 3));
      s.rw       = 5'($urandom_range(0, 3));
      s.uses_rt  = 1'($urandom_range(0, 1));
      s.md_start = ($urandom_range(0, 9) == 0);
      s.md_read  = ($urandom_range(0, 3) == 0);
      s.regwr    = 1'($urandom_range(0, 1));
      s.memtoreg = ($urandom_range(0, 2) == 0);
      s.redirect = !last_redirect && ($urandom_range(0, 9) == 0);
      drive(s);
    end
    drive(idle());

    for (int i = 0; i < 4 && sb.size() != 0; i++) @(negedge clk);
    #1;
    check("scoreboard_drain", cyc, 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
